pipeline_control: RTL
=====================

# pipeline_control

Central sequencing controller for the five-stage core. Each cycle it takes the decode stage's stall, jump and ebreak indications and produces the enables and bubble-insert commands for:

- the PC register,
- the fetch/decode pipeline register,
- the decode/execute pipeline register.

It also owns the post-reset flush, the ebreak drain-and-halt sequence, and a saturating stall-cycle counter used by the testbench. It sits beside the pipeline registers in the CPU top level, between decode outputs and the fetch/register enables.

## Interface
Parameters:
- DRAIN_CYCLES, 3, cycles spent draining after ebreak leaves decode (execute, memory, writeback); legal range 1..15.
- STALL_CNT_WIDTH, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- decode_ready  in  1  decode is not stalling on a register hazard (decode stage_out.ready).
- decode_jump  in  1  decode resolved a taken jump or branch this cycle.
- decode_ebreak  in  1  the instruction currently in decode is ebreak.
- resume  in  1  single-cycle pulse; leave HALTED.
- pc_we  out  1  PC register loads its next value.
- pc_sel_jump  out  1  next PC is the decode pc_next rather than pc+4.
- fd_we  out  1  fetch/decode register loads.
- fd_flush  out  1  fetch/decode register loads a bubble (valid=0); has priority over fd_we.
- de_flush  out  1  decode/execute register loads a bubble instead of decode stage_out.
- halted  out  1  core is halted.
- state  out  2  current FSM state, for debug.
- stall_cycles  out  STALL_CNT_WIDTH  count of cycles spent stalled in RUN.

## Operation
FSM states (pipeline_ctrl_state_t): FLUSH=0, RUN=1, DRAIN=2, HALTED=3.

Outputs are a Mealy function of state and inputs; the state register and counters are registered.

FLUSH:
- Outputs: pc_we=0, fd_flush=1, de_flush=1.
- Next state: RUN unconditionally. Exactly one cycle.

RUN, evaluated in priority order:
1. !decode_ready (stall)
   - Outputs: pc_we=0, fd_we=0, fd_flush=0, de_flush=1.
   - stall_cycles increments, saturating at all-ones.
   - Jump and ebreak are ignored because decode output is invalid while stalling.
2. decode_ebreak
   - Outputs: pc_we=0, fd_flush=1, de_flush=0, so the ebreak proceeds to execute.
   - Next state: DRAIN; the drain counter loads DRAIN_CYCLES-1.
3. decode_jump
   - Outputs: pc_we=1, pc_sel_jump=1, fd_flush=1 (kills the wrong-path fetched instruction), de_flush=0.
4. Otherwise (normal advance)
   - Outputs: pc_we=1, pc_sel_jump=0, fd_we=1, all flushes 0.

DRAIN:
- Outputs: pc_we=0, fd_we=0, fd_flush=1, de_flush=1.
- Each cycle: if the counter is 0, go to HALTED; otherwise decrement it.
- The ebreak therefore reaches writeback before halted rises.

HALTED:
- Outputs: halted=1; all enables 0, all flushes 0. Registers hold, PC frozen at ebreak+4.
- resume=1: next state RUN, and that cycle's outputs stay at the HALTED values.

Output defaults when not stated above: pc_sel_jump=0, halted=0, fd_we=0.

Counter rules:
- The drain counter is 4 bits; no wrap is possible.
- stall_cycles is cleared only by rst and holds in every state except a RUN stall.

Input handling:
- resume outside HALTED is ignored.
- decode_jump and decode_ebreak outside RUN are ignored.

## Timing
- Reset:
  - With rst=1 at an edge, the next state is FLUSH, the drain counter is 0 and stall_cycles is 0, from any state including mid-DRAIN or HALTED.
  - While rst is held, the state stays FLUSH. Outputs are therefore pc_we=0, fd_flush=1, de_flush=1, halted=0, state=0.
- First fetch advance: the first cycle after rst deasserts is the single FLUSH cycle; the next cycle is RUN.
- Control latency: zero cycles. Enables respond combinationally to decode inputs in the same cycle.
- Ebreak sequence: ebreak decoded in cycle T (RUN) → DRAIN during T+1..T+DRAIN_CYCLES → halted=1 from T+DRAIN_CYCLES+1.
- Resume: resume at cycle H → RUN at H+1 → fetch advances at H+1.
- Stall plus jump in the same cycle: the stall wins. The jump is re-evaluated when decode_ready rises.

## Structure
- Add pipeline_ctrl_state_t (2-bit enum) to the cpu_types package.
- All other logic stays local: the FSM, the 4-bit drain counter, and the stall counter.
- One sub-module: sat_counter (parameterised width; ports inc, clear; saturates at all-ones), instantiated for stall_cycles.

## Test plan
- Reset: hold rst 3 cycles, then release → state=0 with fd_flush=de_flush=1 for exactly 1 cycle, then state=1 with pc_we=fd_we=1 and stall_cycles=0.
- Stall: decode_ready=0 for 4 cycles in RUN, with decode_jump=1 during the 2nd → pc_we=0, de_flush=1 and pc_sel_jump=0 throughout; stall_cycles=4 afterwards.
- Jump: decode_jump=1 for one cycle → pc_we=1, pc_sel_jump=1, fd_flush=1, de_flush=0 that cycle; normal advance the next cycle.
- Ebreak with DRAIN_CYCLES=3: decode_ebreak=1 at T → state=2 at T+1..T+3, halted=1 at T+4. resume at T+6 → state=1 and pc_we=1 at T+7.
- Reset mid-DRAIN: assert rst at T+2 → FLUSH the next cycle, halted never rises, stall_cycles=0.
- Saturation: with STALL_CNT_WIDTH=4, stall 20 cycles → stall_cycles=15 and holds.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the five-stage core.
// Holds the pipeline controller state encoding and the drain counter width.
package cpu_types;

    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } pipeline_ctrl_state_t;

    localparam int DRAIN_CNT_WIDTH = 4;

endpackage

// File: rtl/pipeline_control_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_control.sv
// Central sequencing controller: PC / pipeline-register enables and bubbles,
// post-reset flush, ebreak drain-and-halt, and the stall-cycle counter.
module pipeline_control
    import cpu_types::*;
#(
    parameter int DRAIN_CYCLES    = 3,
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       decode_ready,
    input  logic                       decode_jump,
    input  logic                       decode_ebreak,
    input  logic                       resume,
    output logic                       pc_we,
    output logic                       pc_sel_jump,
    output logic                       fd_we,
    output logic                       fd_flush,
    output logic                       de_flush,
    output logic                       halted,
    output logic [1:0]                 state,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_LOAD = DRAIN_CNT_WIDTH'(DRAIN_CYCLES - 1);

    pipeline_ctrl_state_t        state_q, state_next;
    logic [DRAIN_CNT_WIDTH-1:0]  drain_q, drain_next;
    logic                        stall_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FLUSH;
            drain_q <= '0;
        end else begin
            state_q <= state_next;
            drain_q <= drain_next;
        end
    end

    // Mealy outputs: enables react to decode inputs in the same cycle.
    always_comb begin
        state_next  = state_q;
        drain_next  = drain_q;
        stall_inc   = 1'b0;
        pc_we       = 1'b0;
        pc_sel_jump = 1'b0;
        fd_we       = 1'b0;
        fd_flush    = 1'b0;
        de_flush    = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            FLUSH: begin
                fd_flush   = 1'b1;
                de_flush   = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (!decode_ready) begin
                    de_flush  = 1'b1;
                    stall_inc = 1'b1;
                end else if (decode_ebreak) begin
                    fd_flush   = 1'b1;
                    state_next = DRAIN;
                    drain_next = DRAIN_LOAD;
                end else if (decode_jump) begin
                    pc_we       = 1'b1;
                    pc_sel_jump = 1'b1;
                    fd_flush    = 1'b1;
                end else begin
                    pc_we = 1'b1;
                    fd_we = 1'b1;
                end
            end
            DRAIN: begin
                fd_flush = 1'b1;
                de_flush = 1'b1;
                if (drain_q == '0) begin
                    state_next = HALTED;
                end else begin
                    drain_next = drain_q - 1'b1;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = FLUSH;
            end
        endcase
    end

    sat_counter #(
        .WIDTH(STALL_CNT_WIDTH)
    ) u_stall_counter (
        .clk  (clk),
        .clear(rst),
        .inc  (stall_inc),
        .count(stall_cycles)
    );

    assign state = state_q;

endmodule
